// File: rtl/watch_trigger_checker_if.sv
// watch_trigger_checker_if: trigger/count bus between a self-test requester (master) and the checker (slave)
interface watch_trigger_checker_if #(
  parameter int BITS = 2
);
  logic            start;
  logic [7:0]      num_pulses;
  logic [BITS-1:0] count_in;
  logic            trigger_out;
  logic            busy;
  logic            done;
  logic            error;
  logic [7:0]      pass_count;
  logic [7:0]      err_count;
  logic [BITS-1:0] last_count;
  modport master (
    output start, num_pulses, count_in,
    input  trigger_out, busy, done, error, pass_count, err_count, last_count
  );
  modport slave (
    input  start, num_pulses, count_in,
    output trigger_out, busy, done, error, pass_count, err_count, last_count
  );
endinterface

// File: rtl/watch_trigger_checker.sv
// watch_trigger_checker: pulses trigger_out num_pulses times and checks the synchronised count_in advances by one per pulse (ports: wb_clk_i, wb_rst_i, bus = start/num_pulses/count_in in, trigger_out/busy/done/error/pass_count/err_count/last_count out)
module watch_trigger_checker #(
  parameter int BITS        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_HIGH  = 4,
  parameter int TIMEOUT     = 16
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  watch_trigger_checker_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, BASELINE, HIGH, LOW, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][BITS-1:0] sync;
  logic [BITS-1:0] sc, expected, last_count;
  logic [TW-1:0] timer;
  logic [7:0] remaining, pass_count, err_count;
  logic matched, hit, m, low_exit, trigger, error;
  assign sc = sync[SYNC_STAGES-1];
  assign hit = sc == expected;
  assign m = matched | hit;
  assign low_exit = (m && timer >= TW'(PULSE_HIGH - 1)) || timer == TW'(TIMEOUT - 1);
  always_ff @(posedge wb_clk_i) state <= wb_rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !bus.start ? IDLE : |bus.num_pulses ? BASELINE : DONE;
      BASELINE: state_n = timer == TW'(SYNC_STAGES) ? HIGH : BASELINE;
      HIGH:     state_n = timer == TW'(PULSE_HIGH - 1) ? LOW : HIGH;
      LOW:      state_n = !low_exit ? LOW : remaining == 8'd1 ? DONE : HIGH;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // trigger is registered from the next state so it is a clean flop output aligned with HIGH
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync       <= '0;
      trigger    <= 1'b0;
      timer      <= '0;
      remaining  <= '0;
      pass_count <= '0;
      err_count  <= '0;
      error      <= 1'b0;
      matched    <= 1'b0;
      expected   <= '0;
      last_count <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], bus.count_in};
      trigger <= state_n == HIGH;
      timer   <= (state_n == state && state != IDLE) ? timer + 1'b1 : '0;
      if (state == IDLE && bus.start && |bus.num_pulses) begin
        remaining  <= bus.num_pulses;
        pass_count <= '0;
        err_count  <= '0;
        error      <= 1'b0;
      end
      if (state == BASELINE && state_n == HIGH) begin
        last_count <= sc;
        expected   <= sc + 1'b1;
      end
      if (state == HIGH) matched <= 1'b0;
      if (state == LOW) begin
        if (hit) begin
          matched    <= 1'b1;
          last_count <= sc;
        end
        if (low_exit) begin
          remaining <= remaining - 1'b1;
          if (m) begin
            pass_count <= pass_count + {7'd0, pass_count != 8'hff};
            expected   <= expected + 1'b1;
          end else begin
            // timed out: resynchronise to whatever the counter now shows
            err_count  <= err_count + {7'd0, err_count != 8'hff};
            error      <= 1'b1;
            last_count <= sc;
            expected   <= sc + 1'b1;
          end
        end
      end
    end
  end
  always_comb begin
    bus.busy        = state inside {BASELINE, HIGH, LOW};
    bus.done        = state == DONE;
    bus.trigger_out = trigger;
    bus.error       = error;
    bus.pass_count  = pass_count;
    bus.err_count   = err_count;
    bus.last_count  = last_count;
  end
endmodule

// File: tb/tb_watch_trigger_checker.sv
// tb_watch_trigger_checker: scoreboard bench driving watch_trigger_checker against a modelled counter
module tb_watch_trigger_checker;
  localparam int BITS = 2;
  typedef struct {
    int pulses;
    int pass;
    int err;
    int error;
    int last;
    int min_low;
    int max_low;
    int busy_seen;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  watch_trigger_checker_if #(.BITS(BITS)) bus ();
  watch_trigger_checker #(.BITS(BITS), .SYNC_STAGES(2), .PULSE_HIGH(4), .TIMEOUT(16)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int trig_total = 0;
  int pulse_base = 0;
  int skip_at = 0;
  int dones = 0;
  bit stuck = 1'b0;
  logic [BITS-1:0] base = '0;
  exp_t sb[$];
  always @(posedge bus.trigger_out) trig_total++;
  assign bus.count_in = stuck ? base : BITS'(int'(base) + (trig_total - pulse_base)
                        + ((skip_at != 0 && (trig_total - pulse_base) >= skip_at) ? 1 : 0));
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic setup(input logic [BITS-1:0] b, input bit st, input int sk);
    base = b;
    stuck = st;
    skip_at = sk;
    pulse_base = trig_total;
    tick(3);
  endtask
  task automatic pulse_start(input int num);
    bus.start = 1'b1;
    bus.num_pulses = 8'(num);
    tick(1);
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      check("run_timeout", sb.size(), 0);
      sb.delete();
    end
    tick(2);
  endtask
  task automatic wait_trig(input logic v);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.trigger_out == v) seen = 1'b1;
      else tick(1);
    end
    if (!seen) check("trigger_wait_timeout", int'(bus.trigger_out), int'(v));
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_trigger"}, int'(bus.trigger_out), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_error"}, int'(bus.error), 0);
    check({tag, "_pass"}, int'(bus.pass_count), 0);
    check({tag, "_err"}, int'(bus.err_count), 0);
    check({tag, "_last"}, int'(bus.last_count), 0);
  endtask
  int pulses = 0, hi_len = 0, lo_len = 0, min_low = 255, max_low = 0, bad_high = 0;
  bit busy_seen = 1'b0, prev_trig = 1'b0, post = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      pulses = 0; hi_len = 0; lo_len = 0; min_low = 255; max_low = 0; bad_high = 0;
      busy_seen = 1'b0; prev_trig = 1'b0; post = 1'b0;
    end else begin
      if (post) begin
        check("done_one_cycle", int'(bus.done), 0);
        check("busy_after_done", int'(bus.busy), 0);
        post = 1'b0;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.trigger_out && !prev_trig) begin
        pulses++;
        if (pulses > 1) begin
          if (lo_len < min_low) min_low = lo_len;
          if (lo_len > max_low) max_low = lo_len;
        end
        hi_len = 1;
      end else if (bus.trigger_out) hi_len++;
      else if (prev_trig) begin
        if (hi_len != 4) bad_high++;
        lo_len = 1;
      end else lo_len++;
      prev_trig = bus.trigger_out;
      if (bus.done) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no run pending");
        end else begin
          e = sb.pop_front();
          check("pulses", pulses, e.pulses);
          check("pass_count", int'(bus.pass_count), e.pass);
          check("err_count", int'(bus.err_count), e.err);
          check("error", int'(bus.error), e.error);
          check("last_count", int'(bus.last_count), e.last);
          check("min_low", min_low, e.min_low);
          check("max_low", max_low, e.max_low);
          check("busy_seen", int'(busy_seen), e.busy_seen);
          check("busy_on_done", int'(bus.busy), 0);
          check("high_len_bad", bad_high, 0);
        end
        pulses = 0; min_low = 255; max_low = 0; bad_high = 0; busy_seen = 1'b0;
        post = 1'b1;
      end
    end
  end
  initial begin
    int d0;
    bus.start = 1'b0;
    bus.num_pulses = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    setup(2'd2, 1'b0, 0);
    sb.push_back(exp_t'{6, 6, 0, 0, 0, 4, 4, 1});
    pulse_start(6);
    wait_done();
    setup(2'd1, 1'b1, 0);
    sb.push_back(exp_t'{3, 0, 3, 1, 1, 16, 16, 1});
    pulse_start(3);
    wait_done();
    sb.push_back(exp_t'{0, 0, 3, 1, 1, 255, 0, 0});
    pulse_start(0);
    wait_done();
    setup(2'd0, 1'b0, 2);
    sb.push_back(exp_t'{4, 3, 1, 1, 1, 4, 16, 1});
    pulse_start(4);
    wait_done();
    setup(2'd3, 1'b0, 0);
    sb.push_back(exp_t'{2, 2, 0, 0, 1, 4, 4, 1});
    pulse_start(2);
    wait_trig(1'b1);
    wait_trig(1'b0);
    check("busy_in_low", int'(bus.busy), 1);
    pulse_start(9);
    wait_done();
    setup(2'd3, 1'b0, 0);
    d0 = dones;
    pulse_start(3);
    wait_trig(1'b1);
    tick(1);
    check("trigger_high_before_rst", int'(bus.trigger_out), 1);
    check("last_before_rst", int'(bus.last_count), 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero("mid_high_rst");
    tick(30);
    check("no_done_after_rst", dones, d0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/watch_trigger_checker.md
Name: watch_trigger_checker

Overview:
- Drives the trigger input of the homegrown_watch counter with clean, timed pulses and reads the resulting count back, checking that each pulse advances it by exactly one, modulo 2^BITS.
- Sits on the other side of the trigger/count interface: the transmitter of the trigger and the reader of the count.
- Lets a software routine run a self-test over the logic analyzer without bit-banging trigger edges.

Parameters:
- BITS, 2, width of the counter under test.
- SYNC_STAGES, 2, flip-flop stages synchronising count_in into wb_clk_i; minimum 2.
- PULSE_HIGH, 4, trigger high time and minimum trigger low time, in clocks; minimum 1.
- TIMEOUT, 16, maximum clocks spent in LOW waiting for the expected count; must be greater than PULSE_HIGH and at least SYNC_STAGES+2.

Ports:
- wb_clk_i  input  1  sole clock; all state changes on its rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored while busy=1.
- num_pulses  input  8  number of trigger pulses to issue; sampled when start is accepted.
- count_in  input  BITS  count from the counter under test; asynchronous to wb_clk_i.
- trigger_out  output  1  registered trigger to the counter.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at the end of a run.
- error  output  1  sticky flag, set on any timeout; cleared by reset or an accepted start.
- pass_count  output  8  pulses whose count matched; saturates at 255.
- err_count  output  8  pulses that timed out; saturates at 255.
- last_count  output  BITS  last synchronised count value captured.

Behaviour:
- Reset values (wb_rst_i high at an edge): all outputs and all sync stages 0; state IDLE.
- Reset mid-operation: trigger_out is 0 after that same edge; the run is abandoned with no done pulse.
- count_in passes through SYNC_STAGES flops. All comparisons use the synchronised value, called sc.
- All count arithmetic is BITS wide and wraps: expected = (value + 1) mod 2^BITS.
- States: IDLE, BASELINE, HIGH, LOW, DONE.
- IDLE:
  - start=1 and num_pulses!=0: latch remaining=num_pulses; clear pass_count, err_count and error; busy=1; go to BASELINE.
  - start=1 and num_pulses==0: go to DONE with no trigger activity; busy stays 0.
- BASELINE:
  - Wait SYNC_STAGES+1 cycles, because the counter has no reset and its value is unknown.
  - Then set last_count=sc and expected=sc+1; go to HIGH.
- HIGH: trigger_out=1 for exactly PULSE_HIGH cycles, then go to LOW.
- LOW:
  - trigger_out=0. A timer counts from 0; sc is compared with expected every cycle.
  - A match sets the matched flag and latches last_count=sc.
  - Exit when matched=1 and timer >= PULSE_HIGH-1, or when timer = TIMEOUT-1, whichever comes first.
  - Exit with matched=1: pass_count+1 (saturating); expected+1.
  - Exit with matched=0: err_count+1 (saturating); error=1; resynchronise with last_count=sc and expected=sc+1.
  - On every exit: remaining-1. If remaining reaches 0, go to DONE; otherwise clear matched and the timer and go to HIGH.
- DONE: done=1 for one cycle; busy=0 on the same cycle; go to IDLE.
- start arriving during DONE is ignored; it is accepted only in IDLE.
- If sc equals expected and wb_rst_i is high on the same edge, reset wins.
- trigger_out never glitches: it is driven from a register, and low time is always at least PULSE_HIGH cycles.

Test Plan (BITS=2, SYNC_STAGES=2, PULSE_HIGH=4, TIMEOUT=16; the bench models a counter that increments on the rising edge of trigger_out):
- Normal run with wrap: model count starts at 2, num_pulses=6 -> 6 pulses, each 4 cycles high; pass_count=6, err_count=0, error=0, last_count=0; one done pulse; busy low afterwards.
- Stuck counter: model ignores trigger, holds 1, num_pulses=3 -> every LOW lasts 16 cycles; err_count=3, pass_count=0, error=1, last_count=1.
- Skipped count: model starts at 0, pulse 2 jumps 1->3, num_pulses=4 -> pulse 2 times out and resyncs expected to 0; final pass_count=3, err_count=1, last_count=1.
- Zero pulses: start with num_pulses=0 -> done high for one cycle, no trigger_out edge, busy stays 0, counters unchanged.
- Reset mid-HIGH: assert wb_rst_i during the second HIGH cycle of a run -> trigger_out=0 and all outputs 0 after that edge; no done pulse.
- Busy lockout: a second start during LOW with num_pulses=9 -> ignored; the run completes with the original num_pulses.
